// File: rtl/text_buffer_if.sv
// Text buffer bus: byte-stream write channel (valid/ready), pixel-coordinate
// read channel and cursor/status outputs.
//   master: producer/scanner side (drives writes and read coordinates)
//   slave : text_buffer side
interface text_buffer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_char;
  logic [9:0] rd_x;
  logic [9:0] rd_y;
  logic [7:0] char_out;
  logic [6:0] cur_col;
  logic [6:0] cur_row;
  logic       busy;

  modport master (
    output wr_valid, wr_char, rd_x, rd_y,
    input  wr_ready, char_out, cur_col, cur_row, busy
  );

  modport slave (
    input  wr_valid, wr_char, rd_x, rd_y,
    output wr_ready, char_out, cur_col, cur_row, busy
  );
endinterface

// File: rtl/text_buffer.sv
// text_buffer: character-cell screen memory feeding the font ROM stage.
//   px_clk : pixel clock (sole clock)
//   rstn   : async active-low reset; every reset starts a full clear sweep
//   bus    : text_buffer_if.slave
//            wr_valid/wr_ready/wr_char : byte stream (printables + LF/CR/BS/FF)
//            rd_x/rd_y -> char_out     : cell lookup, latency 1, BLANK off-grid
//            cur_col/cur_row           : hardware cursor
//            busy                      : clear sweep in progress
module text_buffer #(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 16,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic          px_clk,
  input  logic          rstn,
  text_buffer_if.slave  bus
);
  localparam int N  = COLS * ROWS;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [6:0]    LAST_COL = 7'(COLS - 1);
  localparam logic [6:0]    LAST_ROW = 7'(ROWS - 1);
  localparam logic [AW-1:0] LAST_ADR = AW'(N - 1);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;
  state_t state_q, state_d;

  logic [AW-1:0] clr_q, clr_d;
  logic [6:0]    col_q, col_d, row_q, row_d;
  logic          oob_q;
  logic [7:0]    rd_q;
  logic          wr_ready, busy;

  // RAM: one write port, one read port, no reset -> maps onto block RAM
  logic [7:0]    mem [0:N-1];
  logic          we;
  logic [AW-1:0] waddr, raddr;
  logic [7:0]    wdata;

  logic xfer;
  assign xfer = bus.wr_valid && wr_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) state_q <= S_CLEAR;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR: if (clr_q == LAST_ADR) state_d = S_IDLE;
      S_IDLE:  if (xfer && bus.wr_char == 8'h0C) state_d = S_CLEAR;
      default: state_d = S_CLEAR;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    wr_ready = 1'b0;
    busy     = 1'b1;
    if (state_q == S_IDLE) begin
      wr_ready = 1'b1;
      busy     = 1'b0;
    end
  end

  // ---------------- cursor / clear counter / write port ----------------
  logic [6:0]  row_inc;
  logic [13:0] cur_lin;
  assign row_inc = (row_q == LAST_ROW) ? 7'd0 : row_q + 7'd1;
  assign cur_lin = 14'(row_q) * 14'(COLS) + 14'(col_q);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    clr_d = clr_q;
    we    = 1'b0;
    waddr = AW'(cur_lin);
    wdata = bus.wr_char;
    if (state_q == S_CLEAR) begin
      we    = 1'b1;
      waddr = clr_q;
      wdata = BLANK;
      clr_d = clr_q + 1'b1;
    end else if (xfer) begin
      case (bus.wr_char)
        8'h0A: begin col_d = 7'd0; row_d = row_inc; end
        8'h0D: col_d = 7'd0;
        8'h08: begin
          if (col_q != 7'd0) col_d = col_q - 7'd1;
          else if (row_q != 7'd0) begin
            col_d = LAST_COL;
            row_d = row_q - 7'd1;
          end
        end
        8'h0C: begin col_d = 7'd0; row_d = 7'd0; clr_d = '0; end
        default: begin
          we = 1'b1;
          if (col_q == LAST_COL) begin
            col_d = 7'd0;
            row_d = row_inc;
          end else begin
            col_d = col_q + 7'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      clr_q <= '0;
      col_q <= 7'd0;
      row_q <= 7'd0;
    end else begin
      clr_q <= clr_d;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // ---------------- read port ----------------
  logic [6:0]  rcx, rcy;
  logic        in_grid;
  logic [13:0] rd_lin;
  assign rcx     = bus.rd_x[9:3];
  assign rcy     = bus.rd_y[9:3];
  assign in_grid = ({1'b0, rcx} < 8'(COLS)) && ({1'b0, rcy} < 8'(ROWS));
  assign rd_lin  = 14'(rcy) * 14'(COLS) + 14'(rcx);
  assign raddr   = in_grid ? AW'(rd_lin) : '0;

  // Read and write in one block with NBAs: same-cell access returns old data
  always_ff @(posedge px_clk) begin
    if (we) mem[waddr] <= wdata;
    rd_q <= mem[raddr];
  end

  // Off-grid flag lives outside the RAM so the BRAM output stays reset-free;
  // resetting it to 1 makes char_out read BLANK out of reset.
  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) oob_q <= 1'b1;
    else       oob_q <= !in_grid;
  end

  assign bus.char_out = oob_q ? BLANK : rd_q;
  assign bus.wr_ready = wr_ready;
  assign bus.busy     = busy;
  assign bus.cur_col  = col_q;
  assign bus.cur_row  = row_q;
endmodule

// File: tb/tb_text_buffer.sv
module tb_text_buffer;
  logic px_clk = 1'b0;
  logic rstn   = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  text_buffer_if bus();

  text_buffer #(.COLS(80), .ROWS(16), .BLANK(8'h20)) dut (
    .px_clk (px_clk),
    .rstn   (rstn),
    .bus    (bus)
  );

  always #5 px_clk = ~px_clk;

  // ---- stimulus helpers (no checking) ----
  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.wr_valid = 1'b1;
    bus.wr_char  = b;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic send_n(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send_byte(b);
  endtask

  task automatic read_cell(input int col, input int row, output logic [7:0] c);
    bus.rd_x = 10'(col * 8);
    bus.rd_y = 10'(row * 8);
    tick();
    c = bus.char_out;
  endtask

  task automatic read_px(input int x, input int y, output logic [7:0] c);
    bus.rd_x = 10'(x);
    bus.rd_y = 10'(y);
    tick();
    c = bus.char_out;
  endtask

  // counts cycles with wr_ready low, bounded
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (!bus.wr_ready && cnt < 3000) begin
      cnt++;
      tick();
    end
  endtask

  // ---- tests ----
  task automatic test_reset();
    int cnt;
    logic [7:0] c;
    rstn = 1'b0;
    repeat (3) @(posedge px_clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs: busy=%b wr_ready=%b required busy=1 wr_ready=0", bus.busy, bus.wr_ready);
    end
    checks++;
    if (bus.cur_col !== 7'd0 || bus.cur_row !== 7'd0 || bus.char_out !== 8'h20) begin
      failures++;
      $display("FAIL reset_vals: col=%0d row=%0d char=%h required 0 0 20", bus.cur_col, bus.cur_row, bus.char_out);
    end
    rstn = 1'b1;
    wait_idle(cnt);
    checks++;
    if (cnt != 1280) begin
      failures++;
      $display("FAIL reset_sweep_len: cycles=%0d required 1280", cnt);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_busy: busy=%b required 0", bus.busy);
    end
    read_cell(0, 0, c);
    checks++;
    if (c !== 8'h20) begin failures++; $display("FAIL clr_0_0: char=%h required 20", c); end
    read_cell(79, 15, c);
    checks++;
    if (c !== 8'h20) begin failures++; $display("FAIL clr_79_15: char=%h required 20", c); end
    read_cell(41, 9, c);
    checks++;
    if (c !== 8'h20) begin failures++; $display("FAIL clr_41_9: char=%h required 20", c); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] c;
    send_byte(8'h41);
    send_byte(8'h42);
    checks++;
    if (bus.cur_col !== 7'd2 || bus.cur_row !== 7'd0) begin
      failures++;
      $display("FAIL b2b_cursor: col=%0d row=%0d required 2 0", bus.cur_col, bus.cur_row);
    end
    read_cell(0, 0, c);
    checks++;
    if (c !== 8'h41) begin failures++; $display("FAIL b2b_cell0: char=%h required 41", c); end
    read_px(8, 0, c);
    checks++;
    if (c !== 8'h42) begin failures++; $display("FAIL b2b_cell1: char=%h required 42", c); end
    // write 'C' to (2,0) while reading the same cell: old contents expected
    bus.rd_x = 10'd16;
    bus.rd_y = 10'd0;
    bus.wr_valid = 1'b1;
    bus.wr_char  = 8'h43;
    tick();
    bus.wr_valid = 1'b0;
    checks++;
    if (bus.char_out !== 8'h20) begin failures++; $display("FAIL rbw_old: char=%h required 20", bus.char_out); end
    tick();
    checks++;
    if (bus.char_out !== 8'h43) begin failures++; $display("FAIL rbw_new: char=%h required 43", bus.char_out); end
  endtask

  task automatic test_wrap();
    logic [7:0] c;
    send_byte(8'h0D);
    send_n(8'h0A, 3);
    send_n(8'h2E, 79);
    checks++;
    if (bus.cur_col !== 7'd79 || bus.cur_row !== 7'd3) begin
      failures++;
      $display("FAIL wrap_setup: col=%0d row=%0d required 79 3", bus.cur_col, bus.cur_row);
    end
    send_byte(8'h5A);
    checks++;
    if (bus.cur_col !== 7'd0 || bus.cur_row !== 7'd4) begin
      failures++;
      $display("FAIL wrap_col: col=%0d row=%0d required 0 4", bus.cur_col, bus.cur_row);
    end
    read_cell(79, 3, c);
    checks++;
    if (c !== 8'h5A) begin failures++; $display("FAIL wrap_cell_Z: char=%h required 5a", c); end
    send_n(8'h0A, 11);
    send_n(8'h2E, 79);
    send_byte(8'h51);
    checks++;
    if (bus.cur_col !== 7'd0 || bus.cur_row !== 7'd0) begin
      failures++;
      $display("FAIL wrap_row: col=%0d row=%0d required 0 0", bus.cur_col, bus.cur_row);
    end
    read_cell(79, 15, c);
    checks++;
    if (c !== 8'h51) begin failures++; $display("FAIL wrap_cell_Q: char=%h required 51", c); end
  endtask

  task automatic test_controls();
    logic [7:0] c;
    send_n(8'h0A, 2);
    send_n(8'h2E, 5);
    send_byte(8'h0A);
    checks++;
    if (bus.cur_col !== 7'd0 || bus.cur_row !== 7'd3) begin
      failures++;
      $display("FAIL lf: col=%0d row=%0d required 0 3", bus.cur_col, bus.cur_row);
    end
    send_n(8'h2E, 7);
    send_byte(8'h0D);
    checks++;
    if (bus.cur_col !== 7'd0 || bus.cur_row !== 7'd3) begin
      failures++;
      $display("FAIL cr: col=%0d row=%0d required 0 3", bus.cur_col, bus.cur_row);
    end
    send_byte(8'h08);
    checks++;
    if (bus.cur_col !== 7'd79 || bus.cur_row !== 7'd2) begin
      failures++;
      $display("FAIL bs_wrap: col=%0d row=%0d required 79 2", bus.cur_col, bus.cur_row);
    end
    read_cell(0, 3, c);
    checks++;
    if (c !== 8'h2E) begin failures++; $display("FAIL bs_noerase: char=%h required 2e", c); end
    send_n(8'h0A, 14);
    checks++;
    if (bus.cur_col !== 7'd0 || bus.cur_row !== 7'd0) begin
      failures++;
      $display("FAIL lf_lastrow: col=%0d row=%0d required 0 0", bus.cur_col, bus.cur_row);
    end
    send_byte(8'h08);
    checks++;
    if (bus.cur_col !== 7'd0 || bus.cur_row !== 7'd0) begin
      failures++;
      $display("FAIL bs_origin: col=%0d row=%0d required 0 0", bus.cur_col, bus.cur_row);
    end
  endtask

  task automatic test_out_of_grid();
    logic [7:0] c;
    send_byte(8'h0A);
    send_n(8'h2E, 7);
    send_byte(8'h23);
    read_cell(7, 1, c);
    checks++;
    if (c !== 8'h23) begin failures++; $display("FAIL oob_ref: char=%h required 23", c); end
    read_px(700, 0, c);
    checks++;
    if (c !== 8'h20) begin failures++; $display("FAIL oob_x700: char=%h required 20", c); end
    read_px(0, 200, c);
    checks++;
    if (c !== 8'h20) begin failures++; $display("FAIL oob_y200: char=%h required 20", c); end
    read_px(640, 0, c);
    checks++;
    if (c !== 8'h20) begin failures++; $display("FAIL oob_x640: char=%h required 20", c); end
    read_px(0, 128, c);
    checks++;
    if (c !== 8'h20) begin failures++; $display("FAIL oob_y128: char=%h required 20", c); end
    read_px(639, 127, c);
    checks++;
    if (c !== 8'h51) begin failures++; $display("FAIL grid_corner: char=%h required 51", c); end
  endtask

  task automatic test_clear_ff();
    int cnt;
    logic [7:0] c;
    bus.wr_valid = 1'b1;
    bus.wr_char  = 8'h0C;
    tick();
    bus.wr_char  = 8'h58;   // held offered during the sweep; must not land
    wait_idle(cnt);
    bus.wr_valid = 1'b0;
    checks++;
    if (cnt != 1280) begin failures++; $display("FAIL ff_sweep_len: cycles=%0d required 1280", cnt); end
    checks++;
    if (bus.cur_col !== 7'd0 || bus.cur_row !== 7'd0) begin
      failures++;
      $display("FAIL ff_cursor: col=%0d row=%0d required 0 0", bus.cur_col, bus.cur_row);
    end
    read_cell(0, 0, c);
    checks++;
    if (c !== 8'h20) begin failures++; $display("FAIL ff_cell_0_0: char=%h required 20", c); end
    read_cell(79, 15, c);
    checks++;
    if (c !== 8'h20) begin failures++; $display("FAIL ff_cell_79_15: char=%h required 20", c); end
    read_cell(7, 1, c);
    checks++;
    if (c !== 8'h20) begin failures++; $display("FAIL ff_cell_7_1: char=%h required 20", c); end
  endtask

  task automatic test_reset_mid_sweep();
    int cnt;
    logic [7:0] c;
    send_byte(8'h41);
    bus.wr_valid = 1'b1;
    bus.wr_char  = 8'h0C;
    tick();
    bus.wr_char  = 8'h4B;
    repeat (600) tick();
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b0 || bus.char_out !== 8'h20) begin
      failures++;
      $display("FAIL midrst_state: busy=%b wr_ready=%b char=%h required 1 0 20", bus.busy, bus.wr_ready, bus.char_out);
    end
    repeat (2) tick();
    rstn = 1'b1;
    wait_idle(cnt);
    bus.wr_valid = 1'b0;
    checks++;
    if (cnt != 1280) begin failures++; $display("FAIL midrst_sweep_len: cycles=%0d required 1280", cnt); end
    checks++;
    if (bus.cur_col !== 7'd0 || bus.cur_row !== 7'd0) begin
      failures++;
      $display("FAIL midrst_cursor: col=%0d row=%0d required 0 0", bus.cur_col, bus.cur_row);
    end
    read_cell(0, 0, c);
    checks++;
    if (c !== 8'h20) begin failures++; $display("FAIL midrst_cell: char=%h required 20", c); end
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_char  = 8'h00;
    bus.rd_x     = 10'd0;
    bus.rd_y     = 10'd0;
    test_reset();
    test_back_to_back();
    test_wrap();
    test_controls();
    test_out_of_grid();
    test_clear_ff();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
